// File: rtl/ram_fifo_ctrl.sv
// Valid/ready FIFO built on a single-port RAM with registered write and
// combinational read, plus a one-word registered output stage.
module ram_fifo_ctrl #(
   parameter int AW    = 4,
   parameter int DW    = 4,
   parameter int DEPTH = 16
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          wr_valid,
   input  logic [DW-1:0] wr_data,
   output logic          wr_ready,
   output logic          rd_valid,
   output logic [DW-1:0] rd_data,
   input  logic          rd_ready,
   output logic [AW:0]   count,
   output logic          full,
   output logic          empty,
   output logic          ram_enable,
   output logic [AW-1:0] ram_ab,
   output logic [DW-1:0] ram_dbi,
   input  logic [DW-1:0] ram_dbo
);

   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   ram_cnt;
   logic          last_grant;   // 0: fetch won the last conflict, 1: write did

   logic fetch_need;
   logic write_need;
   logic grant_write;
   logic grant_fetch;
   logic conflict;
   logic pop;

   // Handshakes: a word moves on a rising edge where valid && ready are both
   // high; ready never depends on the same-side valid, so no loops form.
   always_comb begin
      fetch_need  = (ram_cnt != '0) && (!rd_valid || rd_ready);
      write_need  = wr_valid && (ram_cnt != FULL_CNT);
      conflict    = fetch_need && write_need;
      grant_write = write_need && (!fetch_need || !last_grant);
      grant_fetch = fetch_need && (!write_need || last_grant);
      pop         = rd_valid && rd_ready;
      wr_ready    = (ram_cnt != FULL_CNT) && !(fetch_need && last_grant);
   end

   // Only a write drives the write pointer onto the shared address bus.
   always_comb begin
      ram_enable = grant_write;
      ram_ab     = grant_write ? wr_ptr : rd_ptr;
      ram_dbi    = wr_data;
   end

   always_comb begin
      count = ram_cnt + {{AW{1'b0}}, rd_valid};
      full  = (ram_cnt == FULL_CNT);
      empty = !rd_valid && (ram_cnt == '0);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         ram_cnt    <= '0;
         last_grant <= 1'b0;
         rd_valid   <= 1'b0;
         rd_data    <= '0;
      end else begin
         if (grant_write) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (grant_fetch) begin
            rd_ptr   <= rd_ptr + 1'b1;
            rd_data  <= ram_dbo;
            rd_valid <= 1'b1;
         end else if (pop) begin
            rd_valid <= 1'b0;
         end
         case ({grant_write, grant_fetch})
            2'b10:   ram_cnt <= ram_cnt + 1'b1;
            2'b01:   ram_cnt <= ram_cnt - 1'b1;
            default: ram_cnt <= ram_cnt;
         endcase
         if (conflict) begin
            last_grant <= grant_write;
         end
      end
   end

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Randomised bench for ram_fifo_ctrl: a 16x4 RAM model, a queue-based
// reference of the FIFO, and an in-order scoreboard of accepted words.
module tb_ram_fifo_ctrl;

   localparam int AW    = 4;
   localparam int DW    = 4;
   localparam int DEPTH = 16;

   logic          clk;
   logic          rst_n;
   logic          wr_valid;
   logic [DW-1:0] wr_data;
   logic          wr_ready;
   logic          rd_valid;
   logic [DW-1:0] rd_data;
   logic          rd_ready;
   logic [AW:0]   count;
   logic          full;
   logic          empty;
   logic          ram_enable;
   logic [AW-1:0] ram_ab;
   logic [DW-1:0] ram_dbi;
   logic [DW-1:0] ram_dbo;

   logic [DW-1:0] mem [DEPTH];

   ram_fifo_ctrl #(.AW(AW), .DW(DW), .DEPTH(DEPTH)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .wr_valid   (wr_valid),
      .wr_data    (wr_data),
      .wr_ready   (wr_ready),
      .rd_valid   (rd_valid),
      .rd_data    (rd_data),
      .rd_ready   (rd_ready),
      .count      (count),
      .full       (full),
      .empty      (empty),
      .ram_enable (ram_enable),
      .ram_ab     (ram_ab),
      .ram_dbi    (ram_dbi),
      .ram_dbo    (ram_dbo)
   );

   // RAM: registered write, combinational read
   always @(posedge clk) begin
      if (ram_enable) mem[ram_ab] <= ram_dbi;
   end
   assign ram_dbo = mem[ram_ab];

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // reference model: queue of words in RAM plus the output stage
   logic [DW-1:0] m_q [$];
   logic          m_valid;
   logic [DW-1:0] m_data;
   logic          m_lg;        // 1 when write won the last conflict

   // scoreboard
   logic [DW-1:0] exp_q [$];
   int            n_vec;
   int            n_err;

   task automatic model_reset();
      m_q.delete();
      exp_q.delete();
      m_valid = 1'b0;
      m_data  = '0;
      m_lg    = 1'b0;
   endtask

   // One clock: drive at negedge, compare, then advance model at posedge.
   task automatic step(input logic wv, input logic [DW-1:0] wd, input logic rr,
                       output logic acc);
      int            ram_n;
      logic          fn, wn, gw, gf;
      logic          e_wr_ready;
      logic [DW-1:0] e_pop;
      @(negedge clk);
      wr_valid = wv;
      wr_data  = wd;
      rd_ready = rr;
      #1;
      ram_n      = m_q.size();
      fn         = (ram_n != 0) && (!m_valid || rr);
      wn         = wv && (ram_n != DEPTH);
      gw         = wn && (!fn || !m_lg);
      gf         = fn && (!wn || m_lg);
      e_wr_ready = (ram_n != DEPTH) && !(fn && m_lg);

      n_vec++;
      if (wr_ready !== e_wr_ready) begin
         n_err++;
         $display("FAIL step_wr_ready t=%0t got=%b exp=%b", $time, wr_ready, e_wr_ready);
      end
      n_vec++;
      if (rd_valid !== m_valid) begin
         n_err++;
         $display("FAIL step_rd_valid t=%0t got=%b exp=%b", $time, rd_valid, m_valid);
      end
      n_vec++;
      if (rd_data !== m_data) begin
         n_err++;
         $display("FAIL step_rd_data t=%0t got=%h exp=%h", $time, rd_data, m_data);
      end
      n_vec++;
      if (count !== (AW+1)'(ram_n + int'(m_valid))) begin
         n_err++;
         $display("FAIL step_count t=%0t got=%0d exp=%0d", $time, count, ram_n + int'(m_valid));
      end
      n_vec++;
      if (full !== (ram_n == DEPTH)) begin
         n_err++;
         $display("FAIL step_full t=%0t got=%b exp=%b", $time, full, ram_n == DEPTH);
      end
      n_vec++;
      if (empty !== (!m_valid && ram_n == 0)) begin
         n_err++;
         $display("FAIL step_empty t=%0t got=%b exp=%b", $time, empty, !m_valid && ram_n == 0);
      end
      n_vec++;
      if (ram_enable !== gw) begin
         n_err++;
         $display("FAIL step_ram_enable t=%0t got=%b exp=%b", $time, ram_enable, gw);
      end
      if (gw) begin
         n_vec++;
         if (ram_dbi !== wd) begin
            n_err++;
            $display("FAIL step_ram_dbi t=%0t got=%h exp=%h", $time, ram_dbi, wd);
         end
      end
      if (m_valid && rr) begin
         n_vec++;
         if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL sb_underflow t=%0t got=%h exp=none", $time, rd_data);
         end else begin
            e_pop = exp_q.pop_front();
            if (rd_data !== e_pop) begin
               n_err++;
               $display("FAIL sb_order t=%0t got=%h exp=%h", $time, rd_data, e_pop);
            end
         end
      end

      @(posedge clk);
      if (gf) begin
         m_data  = m_q.pop_front();
         m_valid = 1'b1;
      end else if (m_valid && rr) begin
         m_valid = 1'b0;
      end
      if (gw) begin
         m_q.push_back(wd);
         exp_q.push_back(wd);
      end
      if (wn && fn) m_lg = gw;
      acc = gw;
      #1;
   endtask

   task automatic push_word(input logic [DW-1:0] wd, input logic rr);
      logic acc;
      int   tries;
      acc   = 1'b0;
      tries = 0;
      while (!acc && tries < 20) begin
         step(1'b1, wd, rr, acc);
         tries++;
      end
      n_vec++;
      if (!acc) begin
         n_err++;
         $display("FAIL push_timeout got=not_accepted exp=accepted data=%h", wd);
      end
   endtask

   task automatic drain(input int budget);
      logic acc;
      int   n;
      n = 0;
      while ((m_valid || m_q.size() != 0) && n < budget) begin
         step(1'b0, DW'($urandom_range(0, 15)), 1'b1, acc);
         n++;
      end
      n_vec++;
      if (m_valid || m_q.size() != 0) begin
         n_err++;
         $display("FAIL drain_timeout got=%0d_left exp=0", m_q.size() + int'(m_valid));
      end
   endtask

   task automatic test_reset();
      wr_valid = 1'b0;
      rd_ready = 1'b0;
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      model_reset();
      n_vec++;
      if (count !== '0 || full !== 1'b0 || empty !== 1'b1 || wr_ready !== 1'b1 || rd_valid !== 1'b0) begin
         n_err++;
         $display("FAIL reset_outputs got=cnt%0d/f%b/e%b/wr%b/rv%b exp=cnt0/f0/e1/wr1/rv0",
                  count, full, empty, wr_ready, rd_valid);
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_three_writes();
      logic acc;
      test_reset();
      step(1'b1, 4'h1, 1'b0, acc);
      n_vec++;
      if (!acc) begin
         n_err++;
         $display("FAIL first_write_ready got=%b exp=1", acc);
      end
      push_word(4'h2, 1'b0);
      push_word(4'h3, 1'b0);
      n_vec++;
      if (rd_valid !== 1'b1 || rd_data !== 4'h1 || count !== 5'd3) begin
         n_err++;
         $display("FAIL three_writes got=rv%b/d%h/cnt%0d exp=rv1/d1/cnt3", rd_valid, rd_data, count);
      end
   endtask

   task automatic test_fill_drain();
      logic acc;
      logic [DW-1:0] v;
      test_reset();
      for (int i = 0; i < DEPTH + 1; i++) begin
         v = DW'(i % 16);
         push_word(v, 1'b0);
      end
      for (int i = 0; i < 3; i++) step(1'b1, 4'h7, 1'b0, acc);
      n_vec++;
      if (full !== 1'b1 || wr_ready !== 1'b0 || count !== 5'd17) begin
         n_err++;
         $display("FAIL fill got=f%b/wr%b/cnt%0d exp=f1/wr0/cnt17", full, wr_ready, count);
      end
      for (int i = 0; i < DEPTH + 1; i++) step(1'b0, 4'h0, 1'b1, acc);
      n_vec++;
      if (empty !== 1'b1 || count !== '0) begin
         n_err++;
         $display("FAIL drain_from_full got=e%b/cnt%0d exp=e1/cnt0", empty, count);
      end
   endtask

   task automatic test_stream();
      logic acc;
      test_reset();
      for (int i = 0; i < 40; i++) step(1'b1, DW'(i % 16), 1'b1, acc);
      drain(40);
   endtask

   task automatic test_async_reset();
      logic acc;
      test_reset();
      for (int i = 0; i < 5; i++) push_word(DW'($urandom_range(0, 15)), 1'b0);
      n_vec++;
      if (count !== 5'd5) begin
         n_err++;
         $display("FAIL pre_reset_count got=%0d exp=5", count);
      end
      wr_valid = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      model_reset();
      n_vec++;
      if (rd_valid !== 1'b0 || empty !== 1'b1 || count !== '0) begin
         n_err++;
         $display("FAIL async_reset got=rv%b/e%b/cnt%0d exp=rv0/e1/cnt0", rd_valid, empty, count);
      end
      @(negedge clk);
      rst_n = 1'b1;
      push_word(4'hA, 1'b0);
      step(1'b0, 4'h0, 1'b0, acc);
      n_vec++;
      if (rd_valid !== 1'b1 || rd_data !== 4'hA) begin
         n_err++;
         $display("FAIL post_reset_first got=rv%b/d%h exp=rv1/dA", rd_valid, rd_data);
      end
      drain(10);
   endtask

   task automatic test_push_pop();
      logic acc;
      test_reset();
      push_word(4'h5, 1'b0);
      step(1'b0, 4'h0, 1'b0, acc);
      step(1'b1, 4'h9, 1'b1, acc);
      n_vec++;
      if (count !== 5'd1 || !acc) begin
         n_err++;
         $display("FAIL push_pop_count got=cnt%0d/acc%b exp=cnt1/acc1", count, acc);
      end
      step(1'b0, 4'h0, 1'b0, acc);
      n_vec++;
      if (rd_valid !== 1'b1 || rd_data !== 4'h9) begin
         n_err++;
         $display("FAIL push_pop_data got=rv%b/d%h exp=rv1/d9", rd_valid, rd_data);
      end
      drain(5);
   endtask

   task automatic test_random();
      logic acc;
      test_reset();
      for (int i = 0; i < 400; i++) begin
         step(1'($urandom_range(0, 1)), DW'($urandom_range(0, 15)),
              ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0, acc);
      end
      drain(40);
   endtask

   initial begin
      n_vec    = 0;
      n_err    = 0;
      rst_n    = 1'b1;
      wr_valid = 1'b0;
      wr_data  = '0;
      rd_ready = 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] = '0;
      model_reset();
      test_reset();
      test_three_writes();
      test_fill_drain();
      test_stream();
      test_async_reset();
      test_push_pop();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
